display_7: RTL and testbench

- Registered BCD/hex to 7-segment decoder for one digit of the board's seven-segment display.
- Converts a 4-bit code into active-low segment drives, with one clock of latency.
- Sits between the counter/data path and the segment pins or the digit-scan multiplexer.

---
 rtl/display_7.sv | 67 ++++++
 tb/tb_display_7.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/display_7.sv
// Registered hex/BCD to 7-segment decoder, one clock of latency, {g,f,e,d,c,b,a} bit order.
// Define DISPLAY7_HEX_EN to show hex glyphs A-F; otherwise codes A-F show a single dash.
module display_7 #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] iData,
  input  logic       iBlank,
  output logic [6:0] oData
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] glyphLow;
  logic [6:0] segNext;
  logic [6:0] segReg;

  // Table is kept in board (active-low) form; polarity is applied afterwards.
  always_comb begin
    glyphLow = 7'h7F;
    if (!iBlank) begin
      case (iData)
        4'h0: glyphLow = 7'h40;
        4'h1: glyphLow = 7'h79;
        4'h2: glyphLow = 7'h24;
        4'h3: glyphLow = 7'h30;
        4'h4: glyphLow = 7'h19;
        4'h5: glyphLow = 7'h12;
        4'h6: glyphLow = 7'h02;
        4'h7: glyphLow = 7'h78;
        4'h8: glyphLow = 7'h00;
        4'h9: glyphLow = 7'h10;
`ifdef DISPLAY7_HEX_EN
        4'hA: glyphLow = 7'h08;
        4'hB: glyphLow = 7'h03;
        4'hC: glyphLow = 7'h46;
        4'hD: glyphLow = 7'h21;
        4'hE: glyphLow = 7'h06;
        4'hF: glyphLow = 7'h0E;
`else
        4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: glyphLow = 7'h3F;
`endif
        // Unknown codes blank the digit rather than passing X to the pins.
        default: glyphLow = 7'h7F;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : gPolarity
      assign segNext[gi] = ACTIVE_LOW ? glyphLow[gi] : ~glyphLow[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segReg <= SEG_OFF;
    end else begin
      segReg <= segNext;
    end
  end

  assign oData = segReg;

endmodule

// File: tb/tb_display_7.sv
// Self-checking bench for display_7: both polarities driven in parallel, directed steps
// followed by randomized codes checked against a lit-segment glyph model.
module tb_display_7;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] iData;
  logic       iBlank;
  logic [6:0] oDataLow;
  logic [6:0] oDataHigh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_7 #(.ACTIVE_LOW(1'b1)) dutLow (
    .clk(clk), .rst(rst), .iData(iData), .iBlank(iBlank), .oData(oDataLow)
  );

  display_7 #(.ACTIVE_LOW(1'b0)) dutHigh (
    .clk(clk), .rst(rst), .iData(iData), .iBlank(iBlank), .oData(oDataHigh)
  );

  // Glyphs described by which segments are lit, letters a..g.
  function automatic string glyphOf(input logic [3:0] d);
    case (d)
      4'h0: return "abcdef";
      4'h1: return "bc";
      4'h2: return "abdeg";
      4'h3: return "abcdg";
      4'h4: return "bcfg";
      4'h5: return "acdfg";
      4'h6: return "acdefg";
      4'h7: return "abc";
      4'h8: return "abcdefg";
      4'h9: return "abcdfg";
`ifdef DISPLAY7_HEX_EN
      4'hA: return "abcefg";
      4'hB: return "cdefg";
      4'hC: return "adef";
      4'hD: return "bcdeg";
      4'hE: return "adefg";
      4'hF: return "aefg";
`endif
      default: return "g";
    endcase
  endfunction

  function automatic logic [6:0] refLow(input logic [3:0] d, input logic b);
    logic [6:0] lit;
    string s;
    lit = 7'h00;
    if (!b) begin
      s = glyphOf(d);
      for (int i = 0; i < s.len(); i++) lit[int'(s[i]) - 97] = 1'b1;
    end
    return ~lit;
  endfunction

  task automatic checkVal(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [6:0] expLow);
    checkVal({tag, "_low"}, oDataLow, expLow);
    checkVal({tag, "_high"}, oDataHigh, ~expLow);
  endtask

  task automatic drive(input logic [3:0] d, input logic b);
    @(negedge clk);
    iData  = d;
    iBlank = b;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] sweepExp [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef DISPLAY7_HEX_EN
  logic [6:0] hexExp [6] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
  logic [6:0] hexExp [6] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

  initial begin
    logic [3:0] d;
    logic       b;
    logic [6:0] prevLow;

    rst    = 1'b1;
    iData  = 4'h0;
    iBlank = 1'b0;
    #1;
    checkVal("reset_low", oDataLow, 7'h7F);
    checkVal("reset_high", oDataHigh, 7'h00);

    // First edge after release loads the current code.
    @(negedge clk);
    rst = 1'b0;
    afterEdge();
    checkVal("first_edge_low", oDataLow, 7'h40);
    checkVal("polarity_zero_high", oDataHigh, 7'h3F);

    // Mid-cycle asynchronous reset with iData=8.
    drive(4'h8, 1'b0);
    afterEdge();
    checkBoth("load8", 7'h00);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_rst_low", oDataLow, 7'h7F);
    checkVal("async_rst_high", oDataHigh, 7'h00);
    @(negedge clk);
    rst = 1'b0;
    checkVal("rst_held_low", oDataLow, 7'h7F);
    afterEdge();
    checkBoth("rst_release8", 7'h00);

    // Decimal sweep, each code held 5 cycles.
    for (int k = 0; k < 10; k++) begin
      prevLow = oDataLow;
      drive(4'(k), 1'b0);
      #1;
      checkVal("sweep_hold", oDataLow, prevLow);
      for (int c = 0; c < 5; c++) begin
        afterEdge();
        checkBoth($sformatf("sweep%0d", k), sweepExp[k]);
      end
    end

    for (int k = 0; k < 6; k++) begin
      drive(4'(10 + k), 1'b0);
      afterEdge();
      checkBoth($sformatf("hex%0d", 10 + k), hexExp[k]);
    end

    // Blank overrides the code, then the code returns.
    drive(4'h3, 1'b1);
    afterEdge();
    checkBoth("blank3", 7'h7F);
    drive(4'h3, 1'b0);
    afterEdge();
    checkBoth("unblank3", 7'h30);

    // Input change between edges must not reach the output early.
    drive(4'h1, 1'b0);
    afterEdge();
    checkBoth("lat1", 7'h79);
    drive(4'h7, 1'b0);
    #2;
    checkBoth("lat_hold", 7'h79);
    afterEdge();
    checkBoth("lat7", 7'h78);

    for (int n = 0; n < 150; n++) begin
      d = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0);
      drive(d, b);
      afterEdge();
      checkBoth($sformatf("rand_d%0h_b%0d", d, b), refLow(d, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
